// File: rtl/rc4_message_cracker.sv
// RC4 key-search controller: sequences task1/task2a/task2b per candidate key, muxes the shared RAM ports
// and scans the decrypted message for lowercase/space text. Optional CRACKER_EXT_VALID_EN: valid_flag accepts a key in CHECK.
module rc4_message_cracker (
  input  logic        clk,
  input  logic        reset,
  input  logic        task1_done,
  input  logic        task2a_done,
  input  logic        task2b_done_flag,
  input  logic        valid_flag,
  input  logic [7:0]  Decrypted_Message_q,
  input  logic [4:0]  task2b_Decrypted_Message_address,
  input  logic [7:0]  task2b_Decrypted_Message_data,
  input  logic        task2b_Decrypted_Message_wren,
  input  logic [7:0]  task1_s_address,
  input  logic [7:0]  task1_s_data,
  input  logic        task1_s_wren,
  input  logic [7:0]  task2a_s_address,
  input  logic [7:0]  task2a_s_data,
  input  logic        task2a_s_wren,
  input  logic [7:0]  task2b_s_address,
  input  logic [7:0]  task2b_s_data,
  input  logic        task2b_s_wren,
  output logic [21:0] secret_key,
  output logic        start_task1,
  output logic        start_task2a,
  output logic        start_task2b,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  output logic [4:0]  Decrypted_Message_address,
  output logic [7:0]  Decrypted_Message_data,
  output logic        Decrypted_Message_wren,
  output logic [4:0]  valid_Decrypted_Message_address,
  output logic        valid_Decrypted_Message_wren,
  output logic [9:0]  LED_on
);

  typedef enum logic [3:0] {
    IDLE, START1, WAIT1, START2A, WAIT2A, START2B, WAIT2B, CHECK, NEXT_KEY, FOUND, FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  scan_cnt;
  logic        byte_ok;
  logic        ext_valid;

`ifdef CRACKER_EXT_VALID_EN
  assign ext_valid = valid_flag;
`else
  logic unused_valid_flag;
  assign unused_valid_flag = valid_flag;
  assign ext_valid = 1'b0;
`endif

  assign byte_ok = ((Decrypted_Message_q >= 8'h61) && (Decrypted_Message_q <= 8'h7A)) ||
                   (Decrypted_Message_q == 8'h20);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      scan_cnt   <= '0;
      secret_key <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT2B && task2b_done_flag)
        scan_cnt <= '0;
      else if (state_q == CHECK)
        scan_cnt <= scan_cnt + 6'd1;
      if (state_q == NEXT_KEY && secret_key != '1)
        secret_key <= secret_key + 22'd1;
    end
  end

  // scan_cnt 0 only issues address 0; read data for byte (scan_cnt-1) is judged on counts 1..32
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = START1;
      START1:   state_d = WAIT1;
      WAIT1:    if (task1_done)       state_d = START2A;
      START2A:  state_d = WAIT2A;
      WAIT2A:   if (task2a_done)      state_d = START2B;
      START2B:  state_d = WAIT2B;
      WAIT2B:   if (task2b_done_flag) state_d = CHECK;
      CHECK: begin
        if (ext_valid)
          state_d = FOUND;
        else if (scan_cnt != '0 && !byte_ok)
          state_d = NEXT_KEY;
        else if (scan_cnt == 6'd32)
          state_d = FOUND;
      end
      NEXT_KEY: state_d = (secret_key == '1) ? FAIL : START1;
      FOUND:    state_d = FOUND;
      FAIL:     state_d = FAIL;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    s_address                 = '0;
    s_data                    = '0;
    s_wren                    = 1'b0;
    Decrypted_Message_address = '0;
    Decrypted_Message_data    = '0;
    Decrypted_Message_wren    = 1'b0;
    case (state_q)
      START1, WAIT1: begin
        s_address = task1_s_address;
        s_data    = task1_s_data;
        s_wren    = task1_s_wren;
      end
      START2A, WAIT2A: begin
        s_address = task2a_s_address;
        s_data    = task2a_s_data;
        s_wren    = task2a_s_wren;
      end
      START2B, WAIT2B: begin
        s_address                 = task2b_s_address;
        s_data                    = task2b_s_data;
        s_wren                    = task2b_s_wren;
        Decrypted_Message_address = task2b_Decrypted_Message_address;
        Decrypted_Message_data    = task2b_Decrypted_Message_data;
        Decrypted_Message_wren    = task2b_Decrypted_Message_wren;
      end
      CHECK:   Decrypted_Message_address = valid_Decrypted_Message_address;
      default: ;
    endcase
  end

  assign start_task1  = (state_q == START1);
  assign start_task2a = (state_q == START2A);
  assign start_task2b = (state_q == START2B);

  assign valid_Decrypted_Message_address = scan_cnt[4:0];
  assign valid_Decrypted_Message_wren    = 1'b0;

  assign LED_on = {7'b0,
                   (state_q != IDLE) && (state_q != FOUND) && (state_q != FAIL),
                   (state_q == FAIL),
                   (state_q == FOUND)};

endmodule

// File: tb/tb_rc4_message_cracker.sv
// Directed-vector bench for rc4_message_cracker with a 1-cycle-latency message RAM model.
module tb_rc4_message_cracker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        task1_done = 1'b0, task2a_done = 1'b0, task2b_done_flag = 1'b0, valid_flag = 1'b0;
  logic [7:0]  Decrypted_Message_q = '0;
  logic [4:0]  task2b_Decrypted_Message_address = '0;
  logic [7:0]  task2b_Decrypted_Message_data = '0;
  logic        task2b_Decrypted_Message_wren = 1'b0;
  logic [7:0]  task1_s_address = '0, task1_s_data = '0;
  logic        task1_s_wren = 1'b0;
  logic [7:0]  task2a_s_address = '0, task2a_s_data = '0;
  logic        task2a_s_wren = 1'b0;
  logic [7:0]  task2b_s_address = '0, task2b_s_data = '0;
  logic        task2b_s_wren = 1'b0;
  logic [21:0] secret_key;
  logic        start_task1, start_task2a, start_task2b;
  logic [7:0]  s_address, s_data;
  logic        s_wren;
  logic [4:0]  Decrypted_Message_address;
  logic [7:0]  Decrypted_Message_data;
  logic        Decrypted_Message_wren;
  logic [4:0]  valid_Decrypted_Message_address;
  logic        valid_Decrypted_Message_wren;
  logic [9:0]  LED_on;

  logic [7:0]  mem [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  rc4_message_cracker dut (
    .clk(clk), .reset(reset),
    .task1_done(task1_done), .task2a_done(task2a_done),
    .task2b_done_flag(task2b_done_flag), .valid_flag(valid_flag),
    .Decrypted_Message_q(Decrypted_Message_q),
    .task2b_Decrypted_Message_address(task2b_Decrypted_Message_address),
    .task2b_Decrypted_Message_data(task2b_Decrypted_Message_data),
    .task2b_Decrypted_Message_wren(task2b_Decrypted_Message_wren),
    .task1_s_address(task1_s_address), .task1_s_data(task1_s_data), .task1_s_wren(task1_s_wren),
    .task2a_s_address(task2a_s_address), .task2a_s_data(task2a_s_data), .task2a_s_wren(task2a_s_wren),
    .task2b_s_address(task2b_s_address), .task2b_s_data(task2b_s_data), .task2b_s_wren(task2b_s_wren),
    .secret_key(secret_key),
    .start_task1(start_task1), .start_task2a(start_task2a), .start_task2b(start_task2b),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
    .Decrypted_Message_address(Decrypted_Message_address),
    .Decrypted_Message_data(Decrypted_Message_data),
    .Decrypted_Message_wren(Decrypted_Message_wren),
    .valid_Decrypted_Message_address(valid_Decrypted_Message_address),
    .valid_Decrypted_Message_wren(valid_Decrypted_Message_wren),
    .LED_on(LED_on)
  );

  always #5 clk = ~clk;

  always @(posedge clk) Decrypted_Message_q <= mem[Decrypted_Message_address];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 32; i++) mem[i] = v;
  endtask

  task automatic fill_abc();
    for (int i = 0; i < 32; i++)
      case (i % 4)
        0: mem[i] = 8'h61;
        1: mem[i] = 8'h62;
        2: mem[i] = 8'h63;
        default: mem[i] = 8'h20;
      endcase
  endtask

  // legal-range edges: 'a', 'z', space
  task automatic fill_bounds();
    for (int i = 0; i < 32; i++)
      case (i % 3)
        0: mem[i] = 8'h61;
        1: mem[i] = 8'h7A;
        default: mem[i] = 8'h20;
      endcase
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_dones(input logic v);
    task1_done = v; task2a_done = v; task2b_done_flag = v;
  endtask

  initial begin
    int pulses;
    int led_gaps;
    fill_const(8'h00);

    // reset state and first start pulse
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_led", LED_on, 0);
    check_eq("rst_key", secret_key, 0);
    check_eq("rst_start1", start_task1, 0);
    check_eq("rst_swren", s_wren, 0);
    check_eq("rst_vaddr", valid_Decrypted_Message_address, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("start1_pulse", start_task1, 1);
    check_eq("led_search", LED_on, 10'b100);
    task1_s_address = 8'h33;
    task1_s_wren    = 1'b1;
    @(negedge clk);
    check_eq("start1_once", start_task1, 0);
    check_eq("mux_t1_addr", s_address, 8'h33);
    check_eq("mux_t1_wren", s_wren, 1);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pulses += int'(start_task1);
    end
    check_eq("wait1_hold", pulses, 0);
    check_eq("wait1_led", LED_on, 10'b100);

    // "abc " message from WAIT1: FOUND after 38 edges
    fill_abc();
    set_dones(1'b1);
    task2b_s_address = 8'h5A;
    task2b_s_wren    = 1'b1;
    task2b_Decrypted_Message_wren = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check_eq("mux_2b_saddr", s_address, 8'h5A);
        check_eq("mux_2b_mwren", Decrypted_Message_wren, 1);
      end
      if (k == 5) begin
        check_eq("chk_mwren", Decrypted_Message_wren, 0);
        check_eq("chk_swren", s_wren, 0);
        check_eq("chk_saddr", s_address, 0);
        check_eq("chk_vwren", valid_Decrypted_Message_wren, 0);
      end
      if (k == 37) check_eq("abc_not_yet", LED_on, 10'b100);
      if (k == 38) begin
        check_eq("abc_found_led", LED_on, 10'b001);
        check_eq("abc_found_key", secret_key, 0);
      end
    end
    repeat (4) @(negedge clk);
    check_eq("found_hold_led", LED_on, 10'b001);
    check_eq("found_hold_start", start_task1, 0);
    task2b_s_wren = 1'b0;
    task2b_Decrypted_Message_wren = 1'b0;

    // all-zero message: one key per 9 cycles
    fill_const(8'h00);
    pulse_reset();
    pulses = 0;
    led_gaps = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      pulses += int'(start_task1);
      if (LED_on[2] !== 1'b1) led_gaps++;
      if (k == 9) check_eq("inc_key_before", secret_key, 0);
      if (k == 10) begin
        check_eq("inc_key_after", secret_key, 1);
        check_eq("inc_start1", start_task1, 1);
      end
    end
    check_eq("inc_pulses", pulses, 4);
    check_eq("inc_key_end", secret_key, 3);
    check_eq("inc_led_search", led_gaps, 0);

    // early exit on byte 5 (0x60 just below 'a')
    fill_bounds();
    mem[5] = 8'h60;
    pulse_reset();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 13) check_eq("early_in_check", LED_on, 10'b100);
      if (k == 14) begin
        check_eq("early_nk_start", start_task1, 0);
        check_eq("early_nk_key", secret_key, 0);
      end
      if (k == 15) begin
        check_eq("early_start1", start_task1, 1);
        check_eq("early_key", secret_key, 1);
      end
    end

    // last byte illegal (0x7B just above 'z'): full 33-cycle scan then next key
    fill_bounds();
    mem[31] = 8'h7B;
    pulse_reset();
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k == 40) begin
        check_eq("last_nk_start", start_task1, 0);
        check_eq("last_nk_key", secret_key, 0);
      end
      if (k == 41) begin
        check_eq("last_start1", start_task1, 1);
        check_eq("last_key", secret_key, 1);
      end
    end

    // boundary-legal message accepted
    fill_bounds();
    pulse_reset();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 39) check_eq("bnd_not_yet", LED_on, 10'b100);
      if (k == 40) check_eq("bnd_found", LED_on, 10'b001);
    end

    // key space exhausted
    fill_const(8'h00);
    set_dones(1'b0);
    pulse_reset();
    repeat (2) @(negedge clk);
    force dut.secret_key = 22'h3FFFFF;
    @(negedge clk);
    release dut.secret_key;
    @(negedge clk);
    check_eq("max_key_loaded", secret_key, 22'h3FFFFF);
    set_dones(1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 7) check_eq("max_nextkey_led", LED_on, 10'b100);
      if (k == 8) begin
        check_eq("fail_led", LED_on, 10'b010);
        check_eq("fail_key", secret_key, 22'h3FFFFF);
      end
    end
    repeat (5) @(negedge clk);
    check_eq("fail_hold_led", LED_on, 10'b010);
    check_eq("fail_hold_key", secret_key, 22'h3FFFFF);
    check_eq("fail_hold_start", start_task1, 0);

    // external valid with illegal data
    fill_const(8'h00);
    valid_flag = 1'b1;
    pulse_reset();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
`ifdef CRACKER_EXT_VALID_EN
      if (k == 8)  check_eq("ext_led", LED_on, 10'b001);
      if (k == 10) check_eq("ext_key", secret_key, 0);
`else
      if (k == 8)  check_eq("ext_led", LED_on, 10'b100);
      if (k == 10) check_eq("ext_key", secret_key, 1);
`endif
    end
    valid_flag = 1'b0;

    // reset mid-flight from START2B
    pulse_reset();
    repeat (5) @(negedge clk);
    check_eq("mid_start2b", start_task2b, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_start2b", start_task2b, 0);
    check_eq("mid_rst_led", LED_on, 0);
    check_eq("mid_rst_key", secret_key, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_restart", start_task1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
